// File: rtl/serial_add_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM states, nibble count.
package serial_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nibbleCount(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Existing 4-bit ripple-carry adder, reused by nibble_serial_adder one nibble per clock.
module ripple_carry_adder
    import serial_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                Cin,
    output logic [NIBBLE_W-1:0] Sum,
    output logic                Cout
);

    logic [NIBBLE_W:0] w_carry;

    assign w_carry[0] = Cin;

    genvar i;
    generate
        for (i = 0; i < NIBBLE_W; i++) begin : g_fullAdder
            assign Sum[i]       = A[i] ^ B[i] ^ w_carry[i];
            assign w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
        end
    endgenerate

    assign Cout = w_carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract computed one nibble per clock through a shared 4-bit ripple adder.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module nibble_serial_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int N     = nibbleCount(WIDTH);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N - 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [CNT_W-1:0]    r_k;
    logic [WIDTH-1:0]    r_aQ;
    logic [WIDTH-1:0]    r_bQ;
    logic [WIDTH-1:0]    r_sum;
    logic                r_carry;
    logic                w_accept;
    logic                w_lastNibble;
    logic [NIBBLE_W-1:0] w_aNib;
    logic [NIBBLE_W-1:0] w_bNib;
    logic [NIBBLE_W-1:0] w_sumNib;
    logic                w_coutNib;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_lastNibble = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                if (r_k == LAST_K) begin
                    w_lastNibble = 1'b1;
                    w_nextState  = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_aNib = r_aQ[r_k*NIBBLE_W +: NIBBLE_W];
    assign w_bNib = r_bQ[r_k*NIBBLE_W +: NIBBLE_W];

    ripple_carry_adder u_rca (
        .A    (w_aNib),
        .B    (w_bNib),
        .Cin  (r_carry),
        .Sum  (w_sumNib),
        .Cout (w_coutNib)
    );

    // Subtraction is A + ~B + 1, so B is inverted and the carry forced at accept time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aQ    <= '0;
            r_bQ    <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
        end else if (w_accept) begin
            r_aQ    <= A;
            r_bQ    <= sub ? ~B : B;
            r_carry <= sub ? 1'b1 : Cin;
            r_sum   <= '0;
            r_k     <= '0;
        end else if (r_state == BUSY) begin
            r_sum[r_k*NIBBLE_W +: NIBBLE_W] <= w_sumNib;
            r_carry <= w_coutNib;
            r_k     <= w_lastNibble ? '0 : r_k + 1'b1;
        end
    end

    assign Sum  = r_sum;
    assign Cout = r_carry;

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;
    logic w_carryIntoMsb;

    // The carry into the top bit is recovered from that bit's sum: c = a ^ b ^ s.
    assign w_carryIntoMsb = w_aNib[NIBBLE_W-1] ^ w_bNib[NIBBLE_W-1] ^ w_sumNib[NIBBLE_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (w_lastNibble) begin
            r_ovf <= w_carryIntoMsb ^ w_coutNib;
        end
    end

    assign Ovf = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16); Ovf checked when SERIAL_ADD_OVF_EN is defined.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NNIB  = 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } expect_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             ovf;

    expect_t expQ[$];
    int      total;
    int      bad;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .Ovf       (ovf)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Monitor: pop and compare whenever a result transfer happens.
    always @(negedge clk) begin
        expect_t e;
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("sb_sum", 32'(Sum), 32'(e.sum));
                checkOutput("sb_cout", 32'(Cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
                checkOutput("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic sendOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                          input logic s, input bit push, input logic [WIDTH-1:0] es,
                          input logic ec, input logic eo);
        int n;
        expect_t e;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        A        = a;
        B        = b;
        Cin      = c;
        sub      = s;
        in_valid = 1'b1;
        if (push) begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo;
            expQ.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        A        = ~a;
        B        = a ^ b;
        Cin      = ~c;
        sub      = ~s;
    endtask

    task automatic waitForOutput(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                                 input logic s, input logic [WIDTH-1:0] es, input logic ec,
                                 input logic eo);
        int lat;
        sendOp(a, b, c, s, 1'b1, es, ec, eo);
        waitForOutput(lat);
        checkOutput("latency", 32'(lat), 32'(NNIB));
        @(posedge clk); #1;
    endtask

    initial begin
        int  lat;
        int  n;
        bit  sawValid;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        Cin       = 1'b0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_sum", 32'(Sum), 32'd0);
        checkOutput("rst_cout", 32'(Cout), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed arithmetic vectors.
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        applyStimulus(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        applyStimulus(16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: result held while out_ready is low, extra in_valid ignored.
        out_ready = 1'b0;
        sendOp(16'h1111, 16'h2222, 1'b1, 1'b0, 1'b1, 16'h3334, 1'b0, 1'b0);
        waitForOutput(lat);
        checkOutput("bp_latency", 32'(lat), 32'(NNIB));
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_sum", 32'(Sum), 32'h3334);
            checkOutput("bp_cout", 32'(Cout), 32'd0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            if (i == 1) begin
                A        = 16'h0001;
                B        = 16'h0001;
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_idle_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_idle_out_valid", 32'(out_valid), 32'd0);
        sawValid = 1'b0;
        for (int i = 0; i < NNIB + 2; i++) begin
            if (out_valid) sawValid = 1'b1;
            @(posedge clk); #1;
        end
        checkOutput("bp_pulse_ignored", 32'(sawValid), 32'd0);

        // Reset after two BUSY cycles discards the operation.
        sendOp(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_rst_sum", 32'(Sum), 32'd0);
        checkOutput("mid_rst_cout", 32'(Cout), 32'd0);
        sawValid = 1'b0;
        for (int i = 0; i < NNIB + 2; i++) begin
            if (out_valid) sawValid = 1'b1;
            @(posedge clk); #1;
        end
        checkOutput("mid_rst_discard", 32'(sawValid), 32'd0);
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("queue_drain", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder/subtractor that sits directly upstream of the existing 4-bit `ripple_carry_adder` and drives it. It slices two wide operands into 4-bit nibbles, presents one nibble per clock to that adder, registers the carry between nibbles, and reassembles the result. It exchanges operands and results with its neighbours through a valid/ready handshake.

## Interface
- `WIDTH`, default 16: operand and result width. Must be a multiple of 4 and at least 4.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset. Synchronous and active-high.
- `in_valid` input 1: operand set offered.
- `in_ready` output 1: block can accept an operand set.
- `A` input WIDTH: operand A.
- `B` input WIDTH: operand B.
- `Cin` input 1: carry-in. Ignored when `sub`=1.
- `sub` input 1: 0 computes A+B+Cin; 1 computes A−B.
- `out_valid` output 1: result available.
- `out_ready` input 1: downstream accepts the result.
- `Sum` output WIDTH: result.
- `Cout` output 1: final carry. In subtract mode, 1 means no borrow.
- `Ovf` output 1: signed overflow. Present only with `SERIAL_ADD_OVF_EN`.

## Operation
- N = WIDTH/4 nibbles, processed least-significant nibble first.
- States:
  - IDLE: `in_ready`=1.
  - BUSY: nibble counter k runs 0..N−1.
  - DONE: `out_valid`=1.
- IDLE→BUSY on `in_valid && in_ready`:
  - Capture `A` into `a_q`.
  - Capture `B` into `b_q`, inverted if `sub`=1.
  - Capture the carry register: `Cin` if `sub`=0, else 1.
  - Set k=0.
  - Clear `Sum` to 0.
- Each BUSY cycle:
  - Drive the adder with nibble k of `a_q`, nibble k of `b_q`, and the carry register.
  - Write the adder's `Sum` output into nibble k of `Sum`.
  - Load the adder's `Cout` into the carry register.
  - Increment k.
- BUSY→DONE after the k=N−1 edge. `Cout` equals the final carry register.
- DONE→IDLE on `out_ready` (`out_valid && out_ready`).
- DONE holds `Sum`, `Cout` and `Ovf` stable until the transfer.
- `in_valid` outside IDLE is ignored. Operands are not queued.
- Operands are sampled only at the accept edge. Later changes to `A`, `B`, `Cin` or `sub` have no effect on the operation in flight.
- All arithmetic is modulo 2^WIDTH. No other width extension.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `Sum`=0, `Cout`=0, `Ovf`=0, k=0, carry register 0.
- Latency: accept at edge t. `out_valid` is first high in the cycle following edge t+N, i.e. N cycles after acceptance (4 for WIDTH=16).
- Throughput: one operation per N+2 cycles at best (accept, N BUSY cycles, DONE with `out_ready`=1).
- `in_ready` and `out_valid` are never high in the same cycle.
- `rst` during BUSY or DONE: the next cycle shows reset values, and the in-flight operation is discarded with no output.
- `rst` takes priority over simultaneous `in_valid` or `out_ready`.

## Configuration
- Macro `SERIAL_ADD_OVF_EN`.
- With the macro defined:
  - `Ovf` port exists.
  - It is registered at the k=N−1 edge as (carry into MSB) XOR (carry out of MSB).
  - It is valid with `out_valid` and cleared on reset or accept.
- Without the macro: no `Ovf` port and no related logic.

## Structure
- Shared package `serial_add_pkg` holds:
  - `NIBBLE_W`=4.
  - The state enum `IDLE`/`BUSY`/`DONE`.
  - A function for the nibble count (WIDTH/4).
- One sub-module: the existing 4-bit `ripple_carry_adder` (ports `A`, `B`, `Cin`, `Sum`, `Cout`), instantiated once and time-multiplexed across nibbles.
- Nibble muxing, the carry register, the counter and the FSM live in `nibble_serial_adder`.

## Test plan
- **Basic add:** WIDTH=16, `A`=0x1234, `B`=0x4321, `Cin`=0, `sub`=0 → `Sum`=0x5555, `Cout`=0; `out_valid` 4 cycles after accept.
- **Full carry ripple:** `A`=0xFFFF, `B`=0x0001, `Cin`=0 → `Sum`=0x0000, `Cout`=1. Also `A`=0xFFFF, `B`=0x0000, `Cin`=1 → `Sum`=0x0000, `Cout`=1.
- **Subtract with borrow:** `sub`=1, `A`=0x0005, `B`=0x0007 → `Sum`=0xFFFE, `Cout`=0. Also `A`=0x0007, `B`=0x0005 → `Sum`=0x0002, `Cout`=1.
- **Backpressure:** hold `out_ready`=0 for 3 cycles in DONE → `Sum` and `Cout` stable, `in_ready`=0, a pulsed `in_valid` is ignored; raising `out_ready` → IDLE next cycle.
- **Reset mid-operation:** assert `rst` after 2 BUSY cycles → next cycle `out_valid`=0, `in_ready`=1, `Sum`=0; a following 0x00FF+0x0001 yields 0x0100.
- **Overflow (macro on):** 0x7FFF+0x0001 → `Sum`=0x8000, `Ovf`=1. Also 0x8000−0x0001 (`sub`=1) → `Sum`=0x7FFF, `Ovf`=1.
